fifo_ctrl_1r1w: RTL

- Valid/ready FIFO controller that owns the read/write pointers for an external single-read, single-write RAM with asynchronous read and synchronous write.
- Sits directly upstream of that RAM and turns a streaming producer/consumer pair into RAM write-enable, write-address and read-address signals.
- Read data passes straight from the RAM read port to the consumer, so no data storage exists inside this block.

---
 rtl/fifo_ctrl_1r1w.sv | 84 ++++++++
 1 files changed

// File: rtl/fifo_ctrl_1r1w.sv
// Valid/ready FIFO controller for an external 1R1W RAM with asynchronous
// read and synchronous write. Holds only the read/write pointers; entry data
// lives in the RAM and the head entry is read straight from its read port.
module fifo_ctrl_1r1w #(
    parameter int DataWidth  = 8,
    parameter int NumEntries = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    // producer side
    input  logic                          valid_i,
    input  logic [DataWidth-1:0]          data_i,
    output logic                          ready_o,
    // consumer side
    output logic                          valid_o,
    output logic [DataWidth-1:0]          data_o,
    input  logic                          ready_i,
    // occupancy
    output logic [$clog2(NumEntries):0]   count_o,
    // RAM write port
    output logic                          ram_wr_valid_o,
    output logic [DataWidth-1:0]          ram_wr_data_o,
    output logic [$clog2(NumEntries)-1:0] ram_wr_addr_o,
    // RAM read port
    output logic [$clog2(NumEntries)-1:0] ram_rd_addr_o,
    input  logic [DataWidth-1:0]          ram_rd_data_i
);

    localparam int AddrW = $clog2(NumEntries);
    localparam int PtrW  = AddrW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the addresses coincide.
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;

    logic empty;
    logic full;
    logic enq;
    logic deq;

    // Status derived purely from the pointer pair.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]) &&
                (wr_ptr[AddrW] != rd_ptr[AddrW]);
    end

    // Handshakes: ready is also gated by reset so no write slips in while the
    // pointers are being held at zero.
    always_comb begin
        ready_o = !full && reset_ni;
        valid_o = !empty;
        enq     = valid_i && ready_o;
        deq     = valid_o && ready_i;
    end

    // RAM port drive and consumer data; the head entry is always at rd_ptr,
    // and because full blocks writes the RAM never overwrites it while valid.
    always_comb begin
        ram_wr_valid_o = enq;
        ram_wr_data_o  = data_i;
        ram_wr_addr_o  = wr_ptr[AddrW-1:0];
        ram_rd_addr_o  = rd_ptr[AddrW-1:0];
        data_o         = ram_rd_data_i;
        count_o        = wr_ptr - rd_ptr;
    end

    // Pointer advance on accepted transfers; reset discards all entries.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
